// File: rtl/vram_scan_pkg.sv
// vram_scan_pkg
//   Shared constants and the RAM-slot FSM encoding for the VRAM scan arbiter.
//   160x120 logical pixels at 4 bpp (3 bits used), 4 pixels per 16-bit word,
//   each logical pixel replicated 4x4 onto a 640x480 screen.
`timescale 1ns/1ps

package vram_scan_pkg;

  localparam int ADDR_W       = 13;
  localparam int DATA_W       = 16;
  localparam int PIX_PER_WORD = 4;
  localparam int PIX_W        = 3;
  localparam int SCALE_LOG2   = 2;
  localparam int H_WORDS      = 40;
  localparam int V_LINES      = 120;
  localparam int VRAM_DEPTH   = H_WORDS * V_LINES;
  localparam int GROUP_LEN    = PIX_PER_WORD << SCALE_LOG2;
  localparam int G_W          = $clog2(GROUP_LEN);
  localparam int PX_IDX_W     = $clog2(PIX_PER_WORD);
  localparam int W_W          = $clog2(H_WORDS);
  localparam int SL_W         = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISP_RD  = 2'd1,
    DISP_CAP = 2'd2,
    HOST_OP  = 2'd3
  } ram_state_t;

endpackage

// File: rtl/vram_pixel_shifter.sv
// vram_pixel_shifter
//   Double-buffered word holder (cur/nxt) and group counter that serialises one
//   prefetched VRAM word into GROUP_LEN screen pixels.
// Ports
//   clk, resetn   pixel clock, asynchronous active-low reset
//   line_pre      start of a new active line: restart the group counter
//   pix_active    visible pixel this cycle
//   cap_valid     cap_data holds the next prefetched word
//   cap_data      prefetched word
//   boundary      combinational: first pixel of a group (triggers next fetch)
//   color_px      registered RGB, one clock behind pix_active
//   underrun      sticky: a group started with no prefetched word available
`timescale 1ns/1ps

module vram_pixel_shifter
  import vram_scan_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              line_pre,
  input  logic              pix_active,
  input  logic              cap_valid,
  input  logic [DATA_W-1:0] cap_data,
  output logic              boundary,
  output logic [PIX_W-1:0]  color_px,
  output logic              underrun
);

  logic [DATA_W-1:0]   cur_reg;
  logic [DATA_W-1:0]   nxt_reg;
  logic                nxt_valid_reg;
  logic                blank_reg;
  logic [G_W-1:0]      g_reg;
  logic [DATA_W-1:0]   word;
  logic [PX_IDX_W-1:0] px_idx;
  logic                black;
  logic [PIX_W-1:0]    pix_arr [PIX_PER_WORD];
  logic [PIX_PER_WORD-1:0] pad_bits_unused;

  assign boundary = pix_active && (g_reg == '0);

  // On the first pixel of a group the new word has not been moved into cur yet,
  // so it is read straight from nxt.
  assign word   = (g_reg == '0) ? nxt_reg : cur_reg;
  assign px_idx = g_reg[G_W-1:SCALE_LOG2];
  // A group that started without a valid word stays black for all its pixels.
  assign black  = (g_reg == '0) ? !nxt_valid_reg : blank_reg;

  for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_unpack
    assign pix_arr[gi]         = word[4*gi +: PIX_W];
    assign pad_bits_unused[gi] = word[4*gi + PIX_W];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_reg       <= '0;
      nxt_reg       <= '0;
      nxt_valid_reg <= 1'b0;
      blank_reg     <= 1'b0;
      g_reg         <= '0;
      color_px      <= '0;
      underrun      <= 1'b0;
    end else begin
      if (line_pre)
        g_reg <= '0;
      else if (pix_active)
        g_reg <= g_reg + 1'b1;

      if (boundary) begin
        cur_reg       <= nxt_reg;
        nxt_valid_reg <= 1'b0;
        blank_reg     <= !nxt_valid_reg;
        if (!nxt_valid_reg)
          underrun <= 1'b1;
      end
      // Leftovers from the previous line must never be shown on the new one.
      if (line_pre)
        nxt_valid_reg <= 1'b0;
      if (cap_valid) begin
        nxt_reg       <= cap_data;
        nxt_valid_reg <= 1'b1;
      end

      color_px <= (pix_active && !black) ? pix_arr[px_idx] : '0;
    end
  end

endmodule

// File: rtl/vram_scan_arbiter.sv
// vram_scan_arbiter
//   Shares one single-port synchronous VRAM between display prefetch and a
//   host port. Display fetches have strict priority; the host uses idle slots.
// Ports
//   clk, resetn          pixel clock, asynchronous active-low reset
//   sof, line_pre        frame / line start pulses from the VGA timing generator
//   pix_active           visible pixel
//   color_px             registered RGB output
//   host_valid/ready/we/addr/wdata   host request handshake (ready = accepted)
//   host_rvalid/rdata    host read return
//   ram_en/we/addr/wdata/rdata       VRAM macro port (rdata 1 clk after read)
//   underrun             sticky prefetch underrun flag
// Build option
//   VRAM_ARB_HOST_RD_EN  defined: host reads supported. Undefined: host is
//                        write-only; reads are accepted and dropped.
`timescale 1ns/1ps

module vram_scan_arbiter
  import vram_scan_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              sof,
  input  logic              line_pre,
  input  logic              pix_active,
  output logic [PIX_W-1:0]  color_px,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              underrun
);

`ifdef VRAM_ARB_HOST_RD_EN
  localparam bit HOST_RD = 1'b1;
`else
  localparam bit HOST_RD = 1'b0;
`endif

  ram_state_t        state_reg, state_next;
  logic [SL_W-1:0]   sl_reg;
  logic [SL_W-1:0]   sl_eff;
  logic [SL_W-1:0]   row;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] fetch_addr;
  logic [W_W-1:0]    w_reg;
  logic              more_words;
  logic              disp_req_reg;
  logic              gen_reg;
  logic              tag_reg;
  logic              boundary;
  logic              cap_valid;
  logic              in_range;
  logic              host_ram;

  // sof takes effect before a coincident line_pre.
  assign sl_eff     = sof ? '0 : sl_reg;
  assign row        = sl_eff >> SCALE_LOG2;
  assign line_base  = ADDR_W'(32'(row) * H_WORDS);
  assign more_words = (32'(w_reg) + 1) < H_WORDS;
  assign fetch_addr = base_reg + ADDR_W'(w_reg);
  assign in_range   = 32'(host_addr) < VRAM_DEPTH;
  assign host_ram   = in_range && (host_we || HOST_RD);

  // A capture is only kept if no line_pre happened since its read was issued
  // (gen toggles per line_pre; tag records gen at read time).
  assign cap_valid  = (state_reg == DISP_CAP) && (tag_reg == gen_reg) && !line_pre;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      sl_reg       <= '0;
      base_reg     <= '0;
      w_reg        <= '0;
      disp_req_reg <= 1'b0;
      gen_reg      <= 1'b0;
      tag_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (sof)
        sl_reg <= '0;
      if (line_pre) begin
        base_reg <= line_base;
        w_reg    <= '0;
        sl_reg   <= sl_eff + 1'b1;
        gen_reg  <= ~gen_reg;
      end else if (boundary && more_words) begin
        w_reg <= w_reg + 1'b1;
      end
      // A new request wins over the clear issued by the read it would follow.
      if (line_pre || (boundary && more_words))
        disp_req_reg <= 1'b1;
      else if (state_reg == DISP_RD)
        disp_req_reg <= 1'b0;
      if (state_reg == DISP_RD)
        tag_reg <= gen_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    host_ready = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    case (state_reg)
      IDLE: begin
        if (disp_req_reg)
          state_next = DISP_RD;
        else if (host_valid)
          state_next = HOST_OP;
      end
      DISP_RD: begin
        ram_en     = 1'b1;
        ram_addr   = fetch_addr;
        state_next = DISP_CAP;
      end
      DISP_CAP: begin
        if (disp_req_reg)
          state_next = DISP_RD;
        else if (host_valid)
          state_next = HOST_OP;
        else
          state_next = IDLE;
      end
      HOST_OP: begin
        host_ready = 1'b1;
        if (host_ram) begin
          ram_en    = 1'b1;
          ram_we    = host_we;
          ram_addr  = host_addr;
          ram_wdata = host_wdata;
        end
        state_next = disp_req_reg ? DISP_RD : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef VRAM_ARB_HOST_RD_EN
  logic rd_pend_reg;
  logic rd_inr_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_pend_reg <= 1'b0;
      rd_inr_reg  <= 1'b0;
    end else begin
      rd_pend_reg <= (state_reg == HOST_OP) && !host_we;
      rd_inr_reg  <= in_range;
    end
  end

  // RAM output is already registered; it is valid the cycle after HOST_OP.
  assign host_rvalid = rd_pend_reg;
  assign host_rdata  = (rd_pend_reg && rd_inr_reg) ? ram_rdata : '0;
`else
  assign host_rvalid = 1'b0;
  assign host_rdata  = '0;
`endif

  vram_pixel_shifter u_shifter (
    .clk        (clk),
    .resetn     (resetn),
    .line_pre   (line_pre),
    .pix_active (pix_active),
    .cap_valid  (cap_valid),
    .cap_data   (ram_rdata),
    .boundary   (boundary),
    .color_px   (color_px),
    .underrun   (underrun)
  );

endmodule

// File: tb/tb_vram_scan_arbiter.sv
`timescale 1ns/1ps

module tb_vram_scan_arbiter;

`ifdef VRAM_ARB_HOST_RD_EN
  localparam bit RD_EN = 1'b1;
`else
  localparam bit RD_EN = 1'b0;
`endif
  localparam int DEPTH = 4800;

  logic        clk;
  logic        resetn;
  logic        sof;
  logic        line_pre;
  logic        pix_active;
  logic [2:0]  color_px;
  logic        host_valid;
  logic        host_ready;
  logic        host_we;
  logic [12:0] host_addr;
  logic [15:0] host_wdata;
  logic        host_rvalid;
  logic [15:0] host_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [12:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;
  logic        underrun;

  vram_scan_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .sof         (sof),
    .line_pre    (line_pre),
    .pix_active  (pix_active),
    .color_px    (color_px),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM model (registered read).
  logic [15:0] mem [0:8191];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // Reference model state.
  logic [15:0] exp_mem [0:DEPTH-1];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int disp_row = 0;
  bit flood_en = 1'b0;
  bit exp_underrun = 1'b0;
  int fq_addr[$];
  int fq_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Display fetches: read strobes not belonging to a host slot.
  always @(negedge clk) begin
    if (resetn && ram_en && !ram_we && !host_ready) begin
      fq_addr.push_back(int'(ram_addr));
      fq_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_op(input bit we, input int addr, input logic [15:0] wd);
    bit          acc;
    bit          inr;
    int          n;
    logic [15:0] exp;
    acc = 1'b0;
    n   = 0;
    exp = '0;
    inr = (addr < DEPTH);
    host_valid = 1'b1;
    host_we    = we;
    host_addr  = 13'(addr);
    host_wdata = wd;
    while (!acc && n < 64) begin
      @(negedge clk);
      if (host_ready) begin
        acc = 1'b1;
        if (inr && (we || RD_EN)) begin
          check_eq("host_ram_en", ram_en, 1);
          check_eq("host_ram_cmd", {ram_we, ram_addr}, {we, 13'(addr)});
          if (we) check_eq("host_ram_wdata", ram_wdata, wd);
        end else begin
          check_eq("host_no_ram_en", ram_en, 0);
        end
        if (we && inr) exp_mem[addr] = wd;
        exp = inr ? exp_mem[addr] : 16'h0;
      end
      tick();
      n++;
    end
    host_valid = 1'b0;
    if (!acc) begin
      check_eq("host_timeout", 0, 1);
    end else if (!we) begin
      @(negedge clk);
      if (RD_EN) begin
        check_eq("host_rvalid", host_rvalid, 1);
        check_eq("host_rdata", host_rdata, exp);
      end else begin
        check_eq("host_rvalid_tied", {host_rvalid, host_rdata}, 0);
      end
      tick();
    end
  endtask

  task automatic host_rand();
    int a;
    bit we;
    we = ($urandom_range(0, 3) != 0);
    do a = $urandom_range(0, DEPTH + 15);
    while (a < DEPTH && ((a / 40) == disp_row || (a / 40) == (disp_row + 1) % 120));
    host_op(we, a, 16'($urandom));
  endtask

  // One screen line: line_pre (optionally with sof), gap, optional 640 pixels.
  task automatic do_line(input bit with_sof, input int line_no, input bit show);
    int          base;
    int          nexp;
    int          gap;
    int          lat;
    int          req_cyc [40];
    logic [15:0] w;
    base     = (line_no / 4) * 40;
    disp_row = line_no / 4;
    fq_addr.delete();
    fq_cyc.delete();
    sof        = with_sof;
    line_pre   = 1'b1;
    req_cyc[0] = cyc;
    tick();
    sof      = 1'b0;
    line_pre = 1'b0;
    gap = 3 + $urandom_range(0, 4);
    repeat (gap) tick();
    if (show) begin
      for (int x = 0; x < 640; x++) begin
        pix_active = 1'b1;
        if (x % 16 == 0 && x / 16 < 39) req_cyc[x / 16 + 1] = cyc;
        tick();
        w = exp_mem[base + x / 16];
        check_eq("pixel", color_px, (w >> (4 * ((x % 16) / 4))) & 16'h7);
      end
    end
    pix_active = 1'b0;
    repeat (4) tick();
    nexp = show ? 40 : 1;
    check_eq("fetch_count", fq_addr.size(), nexp);
    for (int k = 0; k < nexp && k < fq_addr.size(); k++) begin
      check_eq("fetch_addr", fq_addr[k], base + k);
      lat = fq_cyc[k] - req_cyc[k];
      check_eq("fetch_latency_le3", (lat >= 1 && lat <= 3), 1);
    end
    check_eq("underrun", underrun, exp_underrun);
    if (show) $display("[TB] line %0d base %0d fetches %0d", line_no, base, fq_addr.size());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          mism;
    bit          got;
    logic [31:0] v;
    resetn     = 1'b0;
    sof        = 1'b0;
    line_pre   = 1'b0;
    pix_active = 1'b0;
    host_valid = 1'b1;
    host_we    = 1'b1;
    host_addr  = 13'd7;
    host_wdata = 16'hdead;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      mem[i]     <= v[15:0];
      exp_mem[i]  = v[15:0];
    end
    mem[0] <= 16'h3210; exp_mem[0] = 16'h3210;
    mem[1] <= 16'h7654; exp_mem[1] = 16'h7654;
    mem[2] <= 16'hba98; exp_mem[2] = 16'hba98;
    mem[3] <= 16'hfedc; exp_mem[3] = 16'hfedc;

    // Reset with a pending host request: everything quiet.
    repeat (4) begin
      @(negedge clk);
      check_eq("rst_host_ready", host_ready, 0);
      check_eq("rst_outputs",
               {ram_en, ram_we, ram_addr, ram_wdata, color_px, underrun, host_rvalid, host_rdata}, 0);
    end
    tick();
    host_valid = 1'b0;
    resetn     = 1'b1;
    tick();
    $display("[TB] reset checks done");

    // Frame 1: lines 0..7 displayed under a host write/read flood.
    sof = 1'b1;
    tick();
    sof = 1'b0;
    tick();
    flood_en = 1'b1;
    fork
      begin
        for (int l = 0; l < 8; l++) do_line(1'b0, l, 1'b1);
        flood_en = 1'b0;
      end
      begin
        while (flood_en) host_rand();
      end
    join
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) mism++;
    check_eq("mem_readback", mism, 0);
    $display("[TB] flood done, %0d word mismatches", mism);

    // Lines 8..478 only prefetch their first word; line 479 is shown.
    for (int l = 8; l < 479; l++) do_line(1'b0, l, 1'b0);
    do_line(1'b0, 479, 1'b1);
    // sof coincident with line_pre restarts at line 0.
    do_line(1'b1, 0, 1'b1);

    // Directed host accesses.
    host_op(1'b1, DEPTH, 16'hbeef);
    $display("[TB] host write addr %0d (out of range)", DEPTH);
    host_op(1'b0, 5, 16'h0);
    $display("[TB] host read addr 5");
    host_op(1'b1, 5, 16'h5a5a);
    $display("[TB] host write addr 5 data 5a5a");
    host_op(1'b0, 5, 16'h0);
    $display("[TB] host read addr 5");
    host_op(1'b0, DEPTH, 16'h0);
    $display("[TB] host read addr %0d (out of range)", DEPTH);

    // Withhold line_pre: the next group has no prefetched word.
    for (int x = 0; x < 16; x++) begin
      pix_active = 1'b1;
      tick();
      check_eq("underrun_black", color_px, 0);
    end
    pix_active = 1'b0;
    tick();
    check_eq("underrun_set", underrun, 1);
    exp_underrun = 1'b1;
    do_line(1'b0, 1, 1'b1);

    // Reset in the middle of an accepted host write.
    host_valid = 1'b1;
    host_we    = 1'b1;
    host_addr  = 13'd10;
    host_wdata = ~exp_mem[10];
    got = 1'b0;
    for (int n = 0; n < 32 && !got; n++) begin
      @(negedge clk);
      got = host_ready;
    end
    check_eq("mid_rst_ready_seen", got, 1);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_ram_en", ram_en, 0);
    check_eq("mid_rst_host_ready", host_ready, 0);
    tick();
    host_valid = 1'b0;
    check_eq("mid_rst_no_write", mem[10], exp_mem[10]);
    check_eq("mid_rst_underrun", underrun, 0);
    resetn = 1'b1;
    tick();
    $display("[TB] mid-transaction reset done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
